ofm_frame: RTL

OFM_FRAME -- requirements
Module: ofm_frame

---
 rtl/ofm_pkg.sv | 26 ++
 rtl/ofm_frame.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ofm_pkg.sv
// Shared definitions for the mm2s-to-tx-FIFO framer: state encoding, control-word
// indices and FIFO word widths.
package ofm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [3:0] TXC_FLAG_DEFAULT = 4'hA;

    // Position of each checksum field within the txc control stream (word 0 carries the flag).
    localparam logic [2:0] WORD_CNTL = 3'd1;
    localparam logic [2:0] WORD_OFFS = 3'd2;
    localparam logic [2:0] WORD_INIT = 3'd3;
    localparam logic [2:0] WORD_SAT  = 3'd7;

    localparam int DATA_W      = 64;
    localparam int KEEP_W      = 8;
    localparam int DATA_FIFO_W = DATA_W + KEEP_W + 1;
    localparam int CSUM_W      = 16;
    localparam int INFO_W      = 2 + 3 * CSUM_W;

endpackage

// File: rtl/ofm_frame.sv
// Splits an AXI-Ethernet mm2s transfer into a data FIFO stream and a per-frame checksum
// info word; frames with a bad control flag are dropped, oversize frames are truncated.
module ofm_frame
    import ofm_pkg::*;
#(
    parameter int unsigned C_MAX_BEATS = 1200,
    parameter logic [3:0]  C_TXC_FLAG  = TXC_FLAG_DEFAULT
) (
    input  logic                   tx_clk,
    input  logic                   tx_reset,
    input  logic [31:0]            txc_tdata,
    input  logic [3:0]             txc_tkeep,
    input  logic                   txc_tlast,
    input  logic                   txc_tvalid,
    output logic                   txc_tready,
    input  logic [DATA_W-1:0]      txd_tdata,
    input  logic [KEEP_W-1:0]      txd_tkeep,
    input  logic                   txd_tlast,
    input  logic                   txd_tvalid,
    output logic                   txd_tready,
    output logic [DATA_FIFO_W-1:0] data_fifo_wdata,
    output logic                   data_fifo_wren,
    input  logic                   data_fifo_afull,
    output logic [INFO_W-1:0]      info_fifo_wdata,
    output logic                   info_fifo_wren,
    input  logic                   info_fifo_afull,
    output logic [31:0]            frame_cnt,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            trunc_cnt
);

    localparam int BEAT_W = ($clog2(C_MAX_BEATS + 1) > 11) ? $clog2(C_MAX_BEATS + 1) : 11;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_MAX_BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    state_t                   state_reg;
    state_t                   state_next;
    logic [3:0]               flag_reg;
    logic [2:0]               word_idx_reg;
    logic [1:0]               csum_cntl_reg;
    logic [CSUM_W-1:0]        csum_begin_reg;
    logic [CSUM_W-1:0]        csum_insert_reg;
    logic [CSUM_W-1:0]        csum_init_reg;
    logic [BEAT_W-1:0]        beat_cnt_reg;
    logic [DATA_FIFO_W-1:0]   data_wdata_reg;
    logic                     data_wren_reg;
    logic [INFO_W-1:0]        info_wdata_reg;
    logic                     info_wren_reg;
    logic [31:0]              frame_cnt_reg;
    logic [15:0]              drop_cnt_reg;
    logic [15:0]              trunc_cnt_reg;

    logic txc_fire;
    logic txd_fire;
    logic at_limit;
    logic unused_txc_tkeep;

    assign unused_txc_tkeep = ^txc_tkeep;

    assign txc_fire = txc_tvalid & txc_tready;
    assign txd_fire = txd_tvalid & txd_tready;
    // The beat being offered now is number C_MAX_BEATS.
    assign at_limit = (beat_cnt_reg == LAST_BEAT);

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        txc_tready = 1'b0;
        txd_tready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                txc_tready = ~info_fifo_afull;
                if (txc_tvalid && !info_fifo_afull) begin
                    if (!txc_tlast) begin
                        state_next = ST_CTRL;
                    end else if (txc_tdata[31:28] == C_TXC_FLAG) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_CTRL: begin
                txc_tready = 1'b1;
                if (txc_tvalid && txc_tlast) begin
                    state_next = (flag_reg == C_TXC_FLAG) ? ST_DATA : ST_DROP;
                end
            end
            ST_DATA: begin
                txd_tready = ~data_fifo_afull;
                if (txd_tvalid && !data_fifo_afull) begin
                    if (txd_tlast) begin
                        state_next = ST_IDLE;
                    end else if (at_limit) begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                txd_tready = 1'b1;
                if (txd_tvalid && txd_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Nothing is accepted in the reset cycle so the abandoned frame cannot leak a beat.
        if (tx_reset) begin
            state_next = ST_IDLE;
            txc_tready = 1'b0;
            txd_tready = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            flag_reg        <= '0;
            word_idx_reg    <= '0;
            csum_cntl_reg   <= '0;
            csum_begin_reg  <= '0;
            csum_insert_reg <= '0;
            csum_init_reg   <= '0;
            beat_cnt_reg    <= '0;
            data_wdata_reg  <= '0;
            data_wren_reg   <= 1'b0;
            info_wdata_reg  <= '0;
            info_wren_reg   <= 1'b0;
            frame_cnt_reg   <= '0;
            drop_cnt_reg    <= '0;
            trunc_cnt_reg   <= '0;
        end else begin
            data_wren_reg <= 1'b0;
            info_wren_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (txc_fire) begin
                        flag_reg        <= txc_tdata[31:28];
                        word_idx_reg    <= WORD_CNTL;
                        csum_cntl_reg   <= '0;
                        csum_begin_reg  <= '0;
                        csum_insert_reg <= '0;
                        csum_init_reg   <= '0;
                        beat_cnt_reg    <= '0;
                    end
                end
                ST_CTRL: begin
                    if (txc_fire) begin
                        case (word_idx_reg)
                            WORD_CNTL: csum_cntl_reg <= txc_tdata[1:0];
                            WORD_OFFS: begin
                                csum_begin_reg  <= txc_tdata[31:16];
                                csum_insert_reg <= txc_tdata[15:0];
                            end
                            WORD_INIT: csum_init_reg <= txc_tdata[15:0];
                            default: ;
                        endcase
                        if (word_idx_reg != WORD_SAT) begin
                            word_idx_reg <= word_idx_reg + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (txd_fire) begin
                        data_wren_reg  <= 1'b1;
                        data_wdata_reg <= {txd_tlast | at_limit, txd_tkeep, txd_tdata};
                        beat_cnt_reg   <= beat_cnt_reg + BEAT_ONE;
                        if (txd_tlast || at_limit) begin
                            info_wren_reg  <= 1'b1;
                            info_wdata_reg <= {csum_cntl_reg, csum_begin_reg,
                                               csum_insert_reg, csum_init_reg};
                            frame_cnt_reg  <= frame_cnt_reg + 32'd1;
                            if (!txd_tlast) begin
                                trunc_cnt_reg <= trunc_cnt_reg + 16'd1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    // A truncated frame also drains here, but only a bad flag counts as a drop.
                    if (txd_fire && txd_tlast && flag_reg != C_TXC_FLAG) begin
                        drop_cnt_reg <= drop_cnt_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_fifo_wdata = data_wdata_reg;
    assign data_fifo_wren  = data_wren_reg;
    assign info_fifo_wdata = info_wdata_reg;
    assign info_fifo_wren  = info_wren_reg;
    assign frame_cnt       = frame_cnt_reg;
    assign drop_cnt        = drop_cnt_reg;
    assign trunc_cnt       = trunc_cnt_reg;

endmodule
